// File: rtl/calc_key_encoder.sv
// Keypad-to-calculator token transmitter: builds decimal number tokens and sends op/equals/clear tokens.
// Optional KEY_FIFO_EN adds a 4-entry keycode FIFO so keys are accepted while a send is in flight.
//
// state    | meaning
// ---------+----------------------------------------------------------
// INIT     | after reset, emit CLR token unconditionally
// IDLE     | accept keys; digits accumulate, others start a send
// SEND_NUM | wait for calc_ready, emit accumulated number
// GAP      | one quiet cycle between strobes
// SEND_OP  | wait for calc_ready (not for F), emit operator token
module calc_key_encoder #(
  parameter int MAX_DIGITS = 9,
  parameter bit AUTO_CLR   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  input  logic        calc_ready,
  output logic        strobe,
  output logic [31:0] token,
  output logic        digit_ovf,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_IDLE     = 3'd1,
    S_SEND_NUM = 3'd2,
    S_GAP      = 3'd3,
    S_SEND_OP  = 3'd4
  } state_t;

  localparam state_t     RST_STATE = AUTO_CLR ? S_INIT : S_IDLE;
  localparam logic [3:0] MAX_NDIG  = 4'(MAX_DIGITS);
  localparam logic [3:0] KEY_CLR   = 4'hF;

  if (MAX_DIGITS > 9 || MAX_DIGITS < 1) begin : g_bad_max_digits
    $error("calc_key_encoder: MAX_DIGITS must be 1..9 to keep numbers below 0x8000000A");
  end

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  ndig_q, ndig_d;
  logic [3:0]  op_q, op_d;
  logic        op_pend_q, op_pend_d;
  logic        ovf_q, ovf_d;
  logic        strobe_q, strobe_d;
  logic [31:0] token_q, token_d;
  logic        key_ready_q, key_ready_d;
  logic        busy_q, busy_d;

  logic        fsm_kv;
  logic [3:0]  fsm_kc;
  logic        send_go;
  logic [31:0] acc_x10;

  assign acc_x10 = (acc_q << 3) + (acc_q << 1);

  // Clear is never held back by calc_ready; the calculator takes it in any state.
  assign send_go = (state_q == S_INIT) ||
                   (state_q == S_SEND_NUM && calc_ready) ||
                   (state_q == S_SEND_OP && (calc_ready || op_q == KEY_CLR));

`ifdef KEY_FIFO_EN
  logic [3:0] fifo_q [4];
  logic [3:0] fifo_d [4];
  logic [2:0] cnt_q, cnt_d;
  logic       push, pop;

  assign push   = key_valid && key_ready_q;
  assign pop    = (state_q == S_IDLE) && (cnt_q != 3'd0);
  assign fsm_kv = pop;
  assign fsm_kc = fifo_q[0];

  // Shift-register FIFO: head always at index 0; an F key discards everything older.
  always_comb begin
    fifo_d = fifo_q;
    cnt_d  = cnt_q;
    if (pop) begin
      for (int i = 0; i < 3; i++) fifo_d[i] = fifo_q[i+1];
      cnt_d = cnt_q - 3'd1;
    end
    if (push) begin
      if (key_code == KEY_CLR) cnt_d = 3'd0;
      fifo_d[cnt_d[1:0]] = key_code;
      cnt_d = cnt_d + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= 4'd0;
    end else begin
      cnt_q  <= cnt_d;
      fifo_q <= fifo_d;
    end
  end
`else
  assign fsm_kv = key_valid && key_ready_q;
  assign fsm_kc = key_code;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      acc_q       <= 32'd0;
      ndig_q      <= 4'd0;
      op_q        <= 4'd0;
      op_pend_q   <= 1'b0;
      ovf_q       <= 1'b0;
      strobe_q    <= 1'b0;
      token_q     <= 32'd0;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ndig_q      <= ndig_d;
      op_q        <= op_d;
      op_pend_q   <= op_pend_d;
      ovf_q       <= ovf_d;
      strobe_q    <= strobe_d;
      token_q     <= token_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ndig_d    = ndig_q;
    op_d      = op_q;
    op_pend_d = op_pend_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_INIT: begin
        op_pend_d = 1'b0;
        state_d   = S_GAP;
      end
      S_IDLE: begin
        if (fsm_kv) begin
          if (fsm_kc <= 4'd9) begin
            if (ndig_q >= MAX_NDIG) begin
              ovf_d = 1'b1;
            end else begin
              acc_d  = acc_x10 + {28'd0, fsm_kc};
              ndig_d = ndig_q + 4'd1;
            end
          end else if (fsm_kc == KEY_CLR) begin
            acc_d     = 32'd0;
            ndig_d    = 4'd0;
            ovf_d     = 1'b0;
            op_d      = KEY_CLR;
            op_pend_d = 1'b1;
            state_d   = S_SEND_OP;
          end else begin
            op_d      = fsm_kc;
            op_pend_d = 1'b1;
            state_d   = (ndig_q != 4'd0) ? S_SEND_NUM : S_SEND_OP;
          end
        end
      end
      S_SEND_NUM: begin
        if (send_go) begin
          acc_d   = 32'd0;
          ndig_d  = 4'd0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = op_pend_q ? S_SEND_OP : S_IDLE;
      end
      S_SEND_OP: begin
        if (send_go) begin
          op_pend_d = 1'b0;
          state_d   = S_GAP;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_comb begin
    strobe_d = send_go;
    token_d  = token_q;
    if (send_go) begin
      case (state_q)
        S_INIT:     token_d = {28'h8000000, KEY_CLR};
        S_SEND_NUM: token_d = acc_q;
        default:    token_d = {28'h8000000, op_q};
      endcase
    end
`ifdef KEY_FIFO_EN
    key_ready_d = (cnt_d != 3'd4);
    busy_d      = (state_d != S_IDLE) || (ndig_d != 4'd0) || (cnt_d != 3'd0);
`else
    key_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE) || (ndig_d != 4'd0);
`endif
  end

  assign key_ready = key_ready_q;
  assign strobe    = strobe_q;
  assign token     = token_q;
  assign digit_ovf = ovf_q;
  assign busy      = busy_q;

endmodule
